// File: rtl/temp_bcd_conv.sv
// temp_bcd_conv
//   Converts one raw ADT7420 temperature word into a sign flag plus
//   hundreds/tens/ones BCD digits of whole degrees C and a truncated
//   tenths digit. The integer part goes through a sequential shift-add-3
//   (double-dabble) converter, one bit per clock.
//
//   Timeline for a word accepted at edge k:
//     k LOAD, k+1 select/negate, k+2..k+10 shift steps, k+11 results and
//     out_valid, busy low again from k+12. The next word can be accepted
//     at edge k+12.
//
// Parameters
//   RES16  0: 13-bit mode, value = raw[15:3] signed, LSB 1/16 C
//          1: 16-bit mode, value = raw[15:0] signed, LSB 1/128 C
//   INT_W  integer-magnitude width shifted through double-dabble (9)
//
// Build option
//   TEMP_CONV_FRAC_EN  defined: tenths digit is computed.
//                      undefined: tenths logic is removed and frac is 0.
//
// Ports
//   CLK_100    in   system clock
//   RSTn       in   asynchronous active-low reset
//   raw_valid  in   one-cycle strobe qualifying raw_data
//   raw_data   in   [15:0] raw temperature register word
//   busy       out  conversion in progress
//   out_valid  out  one-cycle pulse, digit outputs updated
//   overrun    out  one-cycle pulse, raw_valid arrived while busy (dropped)
//   sign       out  1 = negative temperature
//   hun/ten/one out [3:0] BCD integer digits
//   frac       out  [3:0] BCD tenths digit (truncated)
module temp_bcd_conv #(
  parameter bit RES16 = 1'b0,
  parameter int INT_W = 9
) (
  input  logic        CLK_100,
  input  logic        RSTn,
  input  logic        raw_valid,
  input  logic [15:0] raw_data,
  output logic        busy,
  output logic        out_valid,
  output logic        overrun,
  output logic        sign,
  output logic [3:0]  hun,
  output logic [3:0]  ten,
  output logic [3:0]  one,
  output logic [3:0]  frac
);

  localparam int CW = $clog2(INT_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [15:0]      raw_q;
  logic [INT_W-1:0] int_sr;
  logic [11:0]      bcd;
  logic [CW-1:0]    cnt;
  logic             neg_q;

  // Value selection and magnitude. val is sign-extended to 17 bits so the
  // most-negative code negates to its full magnitude (e.g. 0x8000 -> 32768)
  // without overflowing the 16-bit magnitude.
  logic signed [16:0] val;
  logic [15:0]        mag;
  logic [INT_W-1:0]   int_ld;

  always_comb begin
    if (RES16) val = {raw_q[15], raw_q};
    else       val = {{4{raw_q[15]}}, raw_q[15:3]};
    mag    = val[16] ? 16'(-val) : val[15:0];
    int_ld = RES16 ? INT_W'(mag >> 7) : INT_W'(mag >> 4);
  end

  // Add-3 correction on every BCD nibble ahead of the shift.
  logic [11:0] bcd_adj;
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

`ifdef TEMP_CONV_FRAC_EN
  // Tenths = (fraction * 10) >> fraction_bits, multiply as shift-add.
  logic [7:0]  p13;
  logic [10:0] p16;
  logic [3:0]  frac_ld;
  logic [3:0]  frac_q;

  always_comb begin
    p13     = {1'b0, mag[3:0], 3'b0} + {3'b0, mag[3:0], 1'b0};
    p16     = {1'b0, mag[6:0], 3'b0} + {3'b0, mag[6:0], 1'b0};
    frac_ld = RES16 ? 4'(p16 >> 7) : 4'(p13 >> 4);
  end

  always_ff @(posedge CLK_100 or negedge RSTn) begin
    if (!RSTn)                frac_q <= '0;
    else if (state == S_LOAD) frac_q <= frac_ld;
  end

  always_ff @(posedge CLK_100 or negedge RSTn) begin
    if (!RSTn)                frac <= '0;
    else if (state == S_DONE) frac <= frac_q;
  end
`else
  assign frac = 4'd0;
`endif

  always_ff @(posedge CLK_100 or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      raw_q     <= '0;
      int_sr    <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sign      <= 1'b0;
      hun       <= '0;
      ten       <= '0;
      one       <= '0;
    end else begin
      out_valid <= 1'b0;
      // Any word offered outside IDLE (DONE included) is dropped.
      overrun   <= raw_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          busy <= raw_valid;
          if (raw_valid) begin
            raw_q <= raw_data;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          int_sr <= int_ld;
          neg_q  <= val[16];
          bcd    <= '0;
          cnt    <= CW'(INT_W - 1);
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd    <= {bcd_adj[10:0], int_sr[INT_W-1]};
          int_sr <= int_sr << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) state <= S_DONE;
        end
        default: begin
          // busy stays up through the cycle where out_valid is visible.
          sign      <= neg_q;
          hun       <= bcd[11:8];
          ten       <= bcd[7:4];
          one       <= bcd[3:0];
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
